// File: rtl/c1541_iec_pkg.sv
// Shared constants for the host-side IEC transmitter: FSM encodings, error codes
// and the microsecond-to-timer-load conversion.
package c1541_iec_pkg;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_ATN_ASSERT = 4'd1;
  localparam logic [3:0] ST_DEV_WAIT   = 4'd2;
  localparam logic [3:0] ST_ATN_DROP   = 4'd3;
  localparam logic [3:0] ST_READY      = 4'd4;
  localparam logic [3:0] ST_EOI_WAIT   = 4'd5;
  localparam logic [3:0] ST_BIT_LOW    = 4'd6;
  localparam logic [3:0] ST_BIT_HIGH   = 4'd7;
  localparam logic [3:0] ST_FRAME      = 4'd8;
  localparam logic [3:0] ST_ABORT      = 4'd9;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NO_DEV = 2'b01;
  localparam logic [1:0] ERR_FRAME  = 2'b10;
  localparam logic [1:0] ERR_EOI    = 2'b11;

  // Load value for the down-counter: it runs load..0, so the interval is load+1 cycles.
  function automatic int unsigned us2cyc(input int unsigned us, input int unsigned clk_hz);
    longint unsigned prod;
    prod = 64'(us) * 64'(clk_hz);
    return 32'(prod / 64'd1000000 - 64'd1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c1541_iec_timer.sv
// Loadable down-counter shared by every timed phase of the IEC host FSM.
module c1541_iec_timer
  import c1541_iec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_c1541,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         done
);

  always_ff @(posedge clk_c1541) begin
    if (reset)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (value != '0)
      value <= value - W'(1);
  end

  assign done = (value == '0);

endmodule

// File: rtl/c1541_iec_host.sv
// Host-side IEC serial bus talker: sends command/data bytes with ATN and EOI
// signalling towards the emulated 1541 listener.
module c1541_iec_host
  import c1541_iec_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 32000000,
  parameter int unsigned T_BIT_US     = 60,
  parameter int unsigned T_EOI_US     = 250,
  parameter int unsigned T_ACK_US     = 1000,
  parameter int unsigned T_BETWEEN_US = 100,
  parameter int unsigned T_ATN_US     = 20
) (
  input  logic       clk_c1541,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       atn_release,
  output logic       iec_atn_o,
  output logic       iec_clk_o,
  output logic       iec_data_o,
  input  logic       iec_clk_i,
  input  logic       iec_data_i,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned BIT_LD = us2cyc(T_BIT_US, CLK_HZ);
  localparam int unsigned EOI_LD = us2cyc(T_EOI_US, CLK_HZ);
  localparam int unsigned ACK_LD = us2cyc(T_ACK_US, CLK_HZ);
  localparam int unsigned BTW_LD = us2cyc(T_BETWEEN_US, CLK_HZ);
  localparam int unsigned ATN_LD = us2cyc(T_ATN_US, CLK_HZ);
  localparam int unsigned MAX_LD = max2(max2(max2(BIT_LD, EOI_LD), max2(ACK_LD, BTW_LD)), ATN_LD);
  localparam int          TW     = $clog2(MAX_LD + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;

  logic [3:0]    state, state_n;
  logic [1:0]    phase, phase_n;
  logic [2:0]    n, n_n;
  logic [3:0]    n_sum;
  logic [7:0]    byte_r, byte_n;
  logic          eoi_r, eoi_n, rel_r, rel_n;
  logic          atn_r, atn_n, clk_r, clk_n, data_r, data_n;
  logic          err_n;
  logic [1:0]    code_n;

  logic          tmr_load;
  logic [TW-1:0] tmr_load_val, tmr_value;
  logic          tmr_done;
  logic          frame_settled;

  c1541_iec_timer #(.W(TW)) u_timer (
    .clk_c1541 (clk_c1541),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .value     (tmr_value),
    .done      (tmr_done)
  );

  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], iec_clk_i};
      data_sync <= {data_sync[0], iec_data_i};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // The last data bit may still be low in the synchronisers when FRAME begins.
  assign frame_settled = (tmr_value < TW'(ACK_LD - 1));
  assign n_sum         = {1'b0, n} + 4'd1;

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    n_n          = n;
    byte_n       = byte_r;
    eoi_n        = eoi_r;
    rel_n        = rel_r;
    atn_n        = atn_r;
    clk_n        = clk_r;
    data_n       = data_r;
    err_n        = 1'b0;
    code_n       = err_code;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          byte_n  = tx_data;
          eoi_n   = tx_eoi & ~tx_atn;
          rel_n   = 1'b0;
          n_n     = 3'd0;
          phase_n = 2'd0;
          if (tx_atn && atn_r) begin
            state_n      = ST_ATN_ASSERT;
            atn_n        = 1'b0;
            clk_n        = 1'b0;
            data_n       = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(ATN_LD);
          end else if (!tx_atn && !atn_r) begin
            state_n      = ST_ATN_DROP;
            atn_n        = 1'b1;
            clk_n        = 1'b0;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(ATN_LD);
          end else begin
            state_n = ST_READY;
            clk_n   = 1'b1;
            data_n  = 1'b1;
          end
        end else if (atn_release) begin
          rel_n        = 1'b1;
          state_n      = ST_ATN_DROP;
          atn_n        = 1'b1;
          clk_n        = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(ATN_LD);
        end
      end
      ST_ATN_ASSERT: begin
        if (tmr_done) begin
          state_n      = ST_DEV_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(ACK_LD);
        end
      end
      ST_DEV_WAIT: begin
        if (!data_s) begin
          state_n = ST_READY;
          phase_n = 2'd0;
          clk_n   = 1'b1;
          data_n  = 1'b1;
        end else if (tmr_done) begin
          state_n = ST_ABORT;
          err_n   = 1'b1;
          code_n  = ERR_NO_DEV;
          atn_n   = 1'b1;
          clk_n   = 1'b1;
          data_n  = 1'b1;
        end
      end
      ST_ATN_DROP: begin
        if (tmr_done) begin
          clk_n = 1'b1;
          if (rel_r) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_READY;
            phase_n = 2'd0;
            data_n  = 1'b1;
          end
        end
      end
      ST_READY: begin
        // Wait for the listener to release DATA and our own CLK release to be visible.
        if (phase == 2'd0) begin
          if (data_s && clk_s) begin
            tmr_load = 1'b1;
            if (eoi_r) begin
              state_n      = ST_EOI_WAIT;
              tmr_load_val = TW'(EOI_LD);
            end else begin
              phase_n      = 2'd1;
              tmr_load_val = TW'(BIT_LD);
            end
          end
        end else if (tmr_done) begin
          state_n      = ST_BIT_LOW;
          clk_n        = 1'b0;
          data_n       = byte_r[n];
          tmr_load     = 1'b1;
          tmr_load_val = TW'(BIT_LD);
        end
      end
      ST_EOI_WAIT: begin
        case (phase)
          2'd0: begin
            if (tmr_done) begin
              phase_n      = 2'd1;
              tmr_load     = 1'b1;
              tmr_load_val = TW'(ACK_LD);
            end
          end
          2'd1: begin
            if (!data_s) begin
              phase_n = 2'd2;
            end else if (tmr_done) begin
              state_n = ST_ABORT;
              err_n   = 1'b1;
              code_n  = ERR_EOI;
              atn_n   = 1'b1;
              clk_n   = 1'b1;
              data_n  = 1'b1;
            end
          end
          default: begin
            if (data_s) begin
              state_n      = ST_BIT_LOW;
              clk_n        = 1'b0;
              data_n       = byte_r[n];
              tmr_load     = 1'b1;
              tmr_load_val = TW'(BIT_LD);
            end
          end
        endcase
      end
      ST_BIT_LOW: begin
        if (tmr_done) begin
          state_n      = ST_BIT_HIGH;
          clk_n        = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(BIT_LD);
        end
      end
      ST_BIT_HIGH: begin
        if (tmr_done) begin
          n_n      = n_sum[2:0];
          clk_n    = 1'b0;
          tmr_load = 1'b1;
          if (n_sum[3]) begin
            state_n      = ST_FRAME;
            phase_n      = 2'd0;
            data_n       = 1'b1;
            tmr_load_val = TW'(ACK_LD);
          end else begin
            state_n      = ST_BIT_LOW;
            data_n       = byte_r[n_sum[2:0]];
            tmr_load_val = TW'(BIT_LD);
          end
        end
      end
      ST_FRAME: begin
        if (phase == 2'd0) begin
          if (!data_s && frame_settled) begin
            phase_n      = 2'd1;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(BTW_LD);
          end else if (tmr_done) begin
            state_n = ST_ABORT;
            err_n   = 1'b1;
            code_n  = ERR_FRAME;
            atn_n   = 1'b1;
            clk_n   = 1'b1;
            data_n  = 1'b1;
          end
        end else if (tmr_done) begin
          state_n = ST_IDLE;
          if (eoi_r)
            clk_n = 1'b1;
        end
      end
      ST_ABORT: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        atn_n   = 1'b1;
        clk_n   = 1'b1;
        data_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      state    <= ST_IDLE;
      phase    <= 2'd0;
      n        <= 3'd0;
      eoi_r    <= 1'b0;
      rel_r    <= 1'b0;
      atn_r    <= 1'b1;
      clk_r    <= 1'b1;
      data_r   <= 1'b1;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      n        <= n_n;
      eoi_r    <= eoi_n;
      rel_r    <= rel_n;
      atn_r    <= atn_n;
      clk_r    <= clk_n;
      data_r   <= data_n;
      err      <= err_n;
      err_code <= code_n;
    end
  end

  always_ff @(posedge clk_c1541) begin
    byte_r <= byte_n;
  end

  assign tx_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign iec_atn_o  = atn_r;
  assign iec_clk_o  = clk_r;
  assign iec_data_o = data_r;

endmodule

// File: tb/tb_c1541_iec_host.sv
// Directed bench for c1541_iec_host with a small cycle-driven listener model on the
// wired-AND bus; run at 4 MHz so every microsecond is exactly 4 clock cycles.
`timescale 1ns/1ps
module tb_c1541_iec_host;

  localparam int unsigned CLK_HZ  = 4000000;
  localparam int          CPU     = 4;               // cycles per microsecond
  localparam int          BIT_CYC = 60 * CPU;        // 240
  localparam int          ERR_DLY = (20 + 1000) * CPU; // ATN settle + device timeout = 4080
  localparam int          TMO     = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid, tx_atn, tx_eoi, atn_release;
  logic [7:0] tx_data;
  logic       tx_ready, busy, err;
  logic [1:0] err_code;
  logic       iec_atn_o, iec_clk_o, iec_data_o;
  logic       lst_data;
  logic       bus_clk, bus_data;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;

  assign bus_clk  = iec_clk_o;
  assign bus_data = iec_data_o & lst_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c1541_iec_host #(.CLK_HZ(CLK_HZ)) dut (
    .clk_c1541   (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_atn      (tx_atn),
    .tx_eoi      (tx_eoi),
    .atn_release (atn_release),
    .iec_atn_o   (iec_atn_o),
    .iec_clk_o   (iec_clk_o),
    .iec_data_o  (iec_data_o),
    .iec_clk_i   (bus_clk),
    .iec_data_i  (bus_data),
    .busy        (busy),
    .err         (err),
    .err_code    (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Present one byte for a single cycle starting at a negedge; returns on the next negedge.
  task automatic send(input logic [7:0] d, input logic atn, input logic eoi, output int c0);
    tx_data  = d;
    tx_atn   = atn;
    tx_eoi   = eoi;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    c0 = cyc;
    chk("tx_ready_drop", tx_ready, 1'b0);
  endtask

  task automatic wait_clk_lvl(input logic lvl, input string tag);
    int t = 0;
    while (iec_clk_o !== lvl && t < TMO) begin @(negedge clk); t++; end
    chk(tag, iec_clk_o, lvl);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy !== 1'b0 && t < TMO) begin @(negedge clk); t++; end
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_err(input string tag);
    int t = 0;
    while (err !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    chk(tag, err, 1'b1);
  endtask

  // Listener side: sample DATA at each CLK rise, 8 bits LSB first.
  task automatic recv_byte(output logic [7:0] b, output int hi_len, output int rises);
    int t;
    b = 8'h00; hi_len = 0; rises = 0;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (iec_clk_o !== 1'b0 && t < TMO) begin @(negedge clk); t++; end
      t = 0;
      while (iec_clk_o !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (iec_clk_o === 1'b1) rises++;
      b[i] = bus_data;
      t = 0;
      while (iec_clk_o === 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (i == 0) hi_len = t;
    end
  endtask

  initial begin
    int         c0, hi, rises, lows, t;
    logic [7:0] rx;
    logic       prev;
    reset = 1'b1; tx_valid = 1'b0; tx_atn = 1'b0; tx_eoi = 1'b0; atn_release = 1'b0;
    tx_data = 8'h00; lst_data = 1'b1;
    idle_cycles(5);
    reset = 1'b0;
    idle_cycles(2);

    // 1: reset state
    chk("rst_atn", iec_atn_o, 1'b1);
    chk("rst_clk", iec_clk_o, 1'b1);
    chk("rst_data", iec_data_o, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_code", err_code, 2'b00);

    // 2: command byte 0x28 under ATN, device present
    send(8'h28, 1'b1, 1'b0, c0);
    chk("t2_atn_low", iec_atn_o, 1'b0);
    chk("t2_clk_low", iec_clk_o, 1'b0);
    idle_cycles(20);
    lst_data = 1'b0;
    wait_clk_lvl(1'b1, "t2_ready");
    idle_cycles(30);
    lst_data = 1'b1;
    recv_byte(rx, hi, rises);
    chk("t2_byte", rx, 8'h28);
    chk("t2_rises", rises, 8);
    chk("t2_bit_high_len", hi, BIT_CYC);
    chk("t2_frame_clk", iec_clk_o, 1'b0);
    chk("t2_frame_data", iec_data_o, 1'b1);
    idle_cycles(30);
    lst_data = 1'b0;
    wait_idle("t2_idle");
    chk("t2_atn_held", iec_atn_o, 1'b0);
    chk("t2_clk_held", iec_clk_o, 1'b0);
    chk("t2_code", err_code, 2'b00);

    // atn_release alone, then no device on the bus
    lst_data = 1'b1;
    atn_release = 1'b1;
    @(negedge clk);
    atn_release = 1'b0;
    chk("rel_busy", busy, 1'b1);
    wait_idle("rel_idle");
    chk("rel_atn", iec_atn_o, 1'b1);
    chk("rel_clk", iec_clk_o, 1'b1);

    // 3: no device
    send(8'h28, 1'b1, 1'b0, c0);
    wait_err("t3_err");
    chk("t3_err_delay", cyc - c0, ERR_DLY);
    chk("t3_code", err_code, 2'b01);
    chk("t3_rel_atn", iec_atn_o, 1'b1);
    chk("t3_rel_clk", iec_clk_o, 1'b1);
    chk("t3_rel_data", iec_data_o, 1'b1);
    @(negedge clk);
    chk("t3_err_pulse", err, 1'b0);
    wait_idle("t3_idle");
    chk("t3_ready", tx_ready, 1'b1);

    // 4: EOI byte 0x41; listener acks 260 us after start for 60 us
    send(8'h41, 1'b0, 1'b1, c0);
    lows = 0;
    for (int i = 0; i < 260 * CPU; i++) begin
      @(negedge clk);
      if (iec_clk_o !== 1'b1) lows++;
    end
    chk("t4_no_clk_low", lows, 0);
    lst_data = 1'b0;
    idle_cycles(60 * CPU);
    lst_data = 1'b1;
    recv_byte(rx, hi, rises);
    chk("t4_byte", rx, 8'h41);
    chk("t4_rises", rises, 8);
    idle_cycles(30);
    lst_data = 1'b0;
    wait_idle("t4_idle");
    chk("t4_clk_released", iec_clk_o, 1'b1);
    chk("t4_code_held", err_code, 2'b01);

    // 5: frame not acknowledged (last bit 0 exercises the FRAME settle window)
    lst_data = 1'b1;
    send(8'h55, 1'b0, 1'b0, c0);
    recv_byte(rx, hi, rises);
    chk("t5_byte", rx, 8'h55);
    wait_err("t5_err");
    chk("t5_code", err_code, 2'b10);
    chk("t5_rel_clk", iec_clk_o, 1'b1);
    chk("t5_rel_data", iec_data_o, 1'b1);
    wait_idle("t5_idle");
    chk("t5_ready", tx_ready, 1'b1);

    // 6: reset during BIT_HIGH of bit 4 of an ATN command
    send(8'h28, 1'b1, 1'b0, c0);
    idle_cycles(20);
    lst_data = 1'b0;
    wait_clk_lvl(1'b1, "t6_ready");
    idle_cycles(30);
    lst_data = 1'b1;
    rises = 0; t = 0; prev = iec_clk_o;
    while (rises < 5 && t < TMO) begin
      @(negedge clk); t++;
      if (iec_clk_o === 1'b1 && prev === 1'b0) rises++;
      prev = iec_clk_o;
    end
    idle_cycles(10);
    chk("t6_bit4_high", iec_clk_o, 1'b1);
    chk("t6_atn_low", iec_atn_o, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_atn", iec_atn_o, 1'b1);
    chk("t6_rst_clk", iec_clk_o, 1'b1);
    chk("t6_rst_data", iec_data_o, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_code", err_code, 2'b00);
    reset = 1'b0;
    idle_cycles(2);
    send(8'h3F, 1'b0, 1'b0, c0);
    chk("t6_direct_ready_clk", iec_clk_o, 1'b1);
    chk("t6_direct_ready_atn", iec_atn_o, 1'b1);
    recv_byte(rx, hi, rises);
    chk("t6_byte", rx, 8'h3F);
    idle_cycles(30);
    lst_data = 1'b0;
    wait_idle("t6_idle");
    chk("t6_clk_held", iec_clk_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
